reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 50 +++++
 tb/tb_reg_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Parameterized register file: two combinational read ports and one write port, with r0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to a read port whose address matches the write.
module reg_file #(
    parameter int ADDR_WIDTH     = 5,
    parameter int REG_FILE_WIDTH = 32,
    parameter int REG_FILE_NREG  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wrt,
    input  logic [ADDR_WIDTH-1:0]     addrA,
    input  logic [ADDR_WIDTH-1:0]     addrB,
    input  logic [ADDR_WIDTH-1:0]     addrD,
    input  logic [REG_FILE_WIDTH-1:0] d,
    output logic [REG_FILE_WIDTH-1:0] data_a,
    output logic [REG_FILE_WIDTH-1:0] data_b
);

    logic [REG_FILE_NREG-1:0][REG_FILE_WIDTH-1:0] regs_q, regs_d;
    logic                                         wr_hit;

    // A write lands only for an in-range, non-zero destination.
    assign wr_hit = wrt && (addrD != '0) && (int'(addrD) < REG_FILE_NREG);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[addrD] = d;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    function automatic logic [REG_FILE_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] addr);
        logic [REG_FILE_WIDTH-1:0] v;
        v = '0;
        if ((addr != '0) && (int'(addr) < REG_FILE_NREG)) v = regs_q[addr];
`ifdef REG_FILE_BYPASS_EN
        // Write-through is suppressed while reset is held so every read stays zero.
        if (rst_n && wr_hit && (addr == addrD)) v = d;
`endif
        return v;
    endfunction

    assign data_a = rd(addrA);
    assign data_b = rd(addrB);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written corner sequences and
// randomized traffic against an array model; follows REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt;
    logic [4:0]  addrA, addrB, addrD;
    logic [31:0] d;
    logic [31:0] data_a, data_b;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [32];

    reg_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (wrt),
        .addrA  (addrA),
        .addrB  (addrB),
        .addrD  (addrD),
        .d      (d),
        .data_a (data_a),
        .data_b (data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  ad;
        logic [31:0] dv;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain array, r0 never stored, write-through only in the bypass build.
    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        logic [31:0] v;
        v = (!rst_n || ra == 5'd0) ? 32'h0 : mdl[ra];
`ifdef REG_FILE_BYPASS_EN
        if (rst_n && wrt === 1'b1 && addrD != 5'd0 && ra == addrD) v = d;
`endif
        return v;
    endfunction

    task automatic mdl_write(input logic w, input logic [4:0] a, input logic [31:0] v);
        if (w && a != 5'd0) mdl[a] = v;
    endtask

    task automatic clr_mdl();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    initial begin
        clr_mdl();
        rst_n = 1'b0; wrt = 1'b0; addrA = '0; addrB = '0; addrD = '0; d = '0;

        // Reads while in reset, then after release before any write
        #2;
        for (int i = 0; i < 32; i += 10) begin
            addrA = 5'(i); addrB = 5'(31 - i); #1;
            check("rst_hold_a", data_a, 32'h0);
            check("rst_hold_b", data_b, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        addrA = 5'd7; addrB = 5'd31; #1;
        check("post_rst_a", data_a, 32'h0);
        check("post_rst_b", data_b, 32'h0);

        // Directed vectors: one write cycle, then read with wrt low
        tbl[0] = '{1'b1, 5'd6,  32'h0000_4544, 5'd6,  5'd6,  32'h0000_4544, 32'h0000_4544};
        tbl[1] = '{1'b0, 5'd3,  32'hDEAD_BEEF, 5'd3,  5'd6,  32'h0000_0000, 32'h0000_4544};
        tbl[2] = '{1'b1, 5'd0,  32'h0000_4541, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd1,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd31, 5'd1,  32'hFFFF_FFFF, 32'h0000_0001};
        tbl[5] = '{1'b1, 5'd15, 32'h1111_1111, 5'd15, 5'd6,  32'h1111_1111, 32'h0000_4544};
        tbl[6] = '{1'b1, 5'd16, 32'hA5A5_5A5A, 5'd16, 5'd0,  32'hA5A5_5A5A, 32'h0000_0000};
        tbl[7] = '{1'b0, 5'd16, 32'h0BAD_F00D, 5'd16, 5'd15, 32'hA5A5_5A5A, 32'h1111_1111};
        for (int i = 0; i < 8; i++) begin
            wrt = tbl[i].wr; addrD = tbl[i].ad; d = tbl[i].dv;
            @(posedge clk); #1;
            mdl_write(tbl[i].wr, tbl[i].ad, tbl[i].dv);
            wrt = 1'b0; addrA = tbl[i].ra; addrB = tbl[i].rb; #1;
            check($sformatf("vec%0d_a", i), data_a, tbl[i].ea);
            check($sformatf("vec%0d_b", i), data_b, tbl[i].eb);
        end

        // Same-cycle read/write of r15: old value without bypass, new value with it
        wrt = 1'b1; addrD = 5'd15; d = 32'h2222_2222; addrA = 5'd15; addrB = 5'd0; #1;
`ifdef REG_FILE_BYPASS_EN
        check("rw15_pre", data_a, 32'h2222_2222);
`else
        check("rw15_pre", data_a, 32'h1111_1111);
`endif
        check("rw15_r0", data_b, 32'h0);
        @(posedge clk); #1;
        mdl_write(1'b1, 5'd15, 32'h2222_2222);
        wrt = 1'b0; #1;
        check("rw15_post", data_a, 32'h2222_2222);

        // Write to r0 is never forwarded
        wrt = 1'b1; addrD = 5'd0; d = 32'h5555_5555; addrA = 5'd0; addrB = 5'd0; #1;
        check("r0_nobyp_a", data_a, 32'h0);
        check("r0_nobyp_b", data_b, 32'h0);
        @(posedge clk); #1;
        wrt = 1'b0; #1;
        check("r0_after", data_a, 32'h0);

        // Undriven address/data with wrt low must leave state alone
        addrD = 'x; d = 'x;
        @(posedge clk); #1;
        addrA = 5'd31; addrB = 5'd6; #1;
        check("x_nop_a", data_a, 32'hFFFF_FFFF);
        check("x_nop_b", data_b, 32'h0000_4544);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            wrt   = 1'($urandom_range(0, 1));
            addrD = 5'($urandom);
            d     = $urandom;
            addrA = ($urandom_range(0, 3) == 0) ? addrD : 5'($urandom);
            addrB = ($urandom_range(0, 3) == 0) ? addrD : 5'($urandom);
            #1;
            check("rnd_pre_a", data_a, exp_rd(addrA));
            check("rnd_pre_b", data_b, exp_rd(addrB));
            @(posedge clk); #1;
            mdl_write(wrt, addrD, d);
            wrt = 1'b0; #1;
            check("rnd_post_a", data_a, exp_rd(addrA));
        end

        // Fill every register so the reset clear is observable everywhere
        for (int i = 1; i < 32; i++) begin
            wrt = 1'b1; addrD = 5'(i); d = 32'hC000_0000 | 32'(i);
            @(posedge clk); #1;
            mdl_write(1'b1, 5'(i), 32'hC000_0000 | 32'(i));
        end
        wrt = 1'b0; addrA = 5'd9; #1;
        check("fill_r9", data_a, 32'hC000_0009);

        // Mid-cycle reset with a pending write: clears at once and blocks the write
        #2;
        wrt = 1'b1; addrD = 5'd5; d = 32'hAAAA_AAAA;
        rst_n = 1'b0;
        clr_mdl();
        for (int i = 0; i < 32; i++) begin
            addrA = 5'(i); addrB = 5'(i); #1;
            check($sformatf("midrst_a%0d", i), data_a, 32'h0);
        end
        check("midrst_b", data_b, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; wrt = 1'b0;
        addrA = 5'd5; addrB = 5'd31; #1;
        check("rst_prio_r5", data_a, 32'h0);
        check("rst_clr_r31", data_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
